// File: rtl/mem_master_if.sv
// Bus bundle between the memory initiator and its neighbours: the CPU
// sequencer (op_* request side, status outputs) and the byte-wide
// ram_memory responder (mem_* side).
//   master : view taken by mem_master
//   slave  : view taken by the CPU + responder (or a testbench)
interface mem_master_if;
   logic        op_valid;
   logic [2:0]  op;
   logic [11:0] op_addr;
   logic [7:0]  op_wdata;
   logic        op_ready;
   logic        done;
   logic [15:0] rd_data;
   logic        err;
   logic [7:0]  sp;
   logic        mem_memreq;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   modport master (
      input  op_valid, op, op_addr, op_wdata, mem_rdata,
      output op_ready, done, rd_data, err, sp,
             mem_memreq, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output op_valid, op, op_addr, op_wdata, mem_rdata,
      input  op_ready, done, rd_data, err, sp,
             mem_memreq, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_master.sv
// Memory-bus initiator. Takes one READ/WRITE/PUSH/POP/READ16 at a time from
// the CPU, drives the responder request lines (all registered), captures the
// read data that arrives one cycle after each read request, and owns the
// descending hardware stack pointer (stack lives in page STACK_PAGE).
// Ports:
//   clk     : system clock, all state changes on the rising edge
//   reset   : synchronous, active-high
//   io_bus  : mem_master_if.master (CPU op/status + responder mem_* lines)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | op_ready=1, waiting for op_valid
// ACC0  | first request on the bus (write commits or read is registered)
// ACC1  | first read byte on mem_rdata; READ16 issues its second request
// CAP1  | READ16 low byte on mem_rdata
// DONE  | done pulse (err with it if flagged), then back to IDLE
module mem_master #(
   parameter logic [3:0] STACK_PAGE = 4'hF,
   parameter logic [7:0] SP_RESET   = 8'hFF
) (
   input  logic         clk,
   input  logic         reset,
   mem_master_if.master io_bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACC0,
      S_ACC1,
      S_CAP1,
      S_DONE
   } state_t;

   localparam logic [2:0] OP_READ   = 3'd0;
   localparam logic [2:0] OP_WRITE  = 3'd1;
   localparam logic [2:0] OP_PUSH   = 3'd2;
   localparam logic [2:0] OP_POP    = 3'd3;
   localparam logic [2:0] OP_READ16 = 3'd4;

   state_t      r_state;
   logic [2:0]  r_op;
   logic        r_err_pend;
   logic [7:0]  r_hi;
   logic        r_op_ready;
   logic        r_done;
   logic        r_err;
   logic [15:0] r_rd_data;
   logic [7:0]  r_sp;
   logic        r_mem_memreq;
   logic        r_mem_we;
   logic [11:0] r_mem_addr;
   logic [7:0]  r_mem_wdata;

   logic [7:0]  w_sp_inc;
   logic [7:0]  w_sp_dec;

   assign w_sp_inc = r_sp + 8'd1;
   assign w_sp_dec = r_sp - 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_op         <= OP_READ;
         r_err_pend   <= 1'b0;
         r_hi         <= 8'h00;
         r_op_ready   <= 1'b1;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_rd_data    <= 16'h0000;
         r_sp         <= SP_RESET;
         r_mem_memreq <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= 12'h000;
         r_mem_wdata  <= 8'h00;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (io_bus.op_valid) begin
                  r_op       <= io_bus.op;
                  r_op_ready <= 1'b0;
                  r_err_pend <= 1'b0;
                  case (io_bus.op)
                     OP_READ, OP_READ16: begin
                        r_mem_memreq <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= io_bus.op_addr;
                        r_state      <= S_ACC0;
                     end
                     OP_WRITE: begin
                        r_mem_memreq <= 1'b1;
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= io_bus.op_addr;
                        r_mem_wdata  <= io_bus.op_wdata;
                        r_state      <= S_ACC0;
                     end
                     OP_PUSH: begin
                        // sp points at the next free slot: write there, then move down
                        r_mem_memreq <= 1'b1;
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= {STACK_PAGE, r_sp};
                        r_mem_wdata  <= io_bus.op_wdata;
                        r_sp         <= w_sp_dec;
                        r_err_pend   <= (r_sp == 8'h00);
                        r_state      <= S_ACC0;
                     end
                     OP_POP: begin
                        r_mem_memreq <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= {STACK_PAGE, w_sp_inc};
                        r_sp         <= w_sp_inc;
                        r_err_pend   <= (r_sp == 8'hFF);
                        r_state      <= S_ACC0;
                     end
                     default: begin
                        // illegal op: no bus activity, report straight away
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                     end
                  endcase
               end
            end
            S_ACC0: begin
               r_mem_memreq <= 1'b0;
               r_mem_we     <= 1'b0;
               if (r_op == OP_WRITE || r_op == OP_PUSH) begin
                  r_done  <= 1'b1;
                  r_err   <= r_err_pend;
                  r_state <= S_DONE;
               end else begin
                  if (r_op == OP_READ16) begin
                     // second byte request; 12-bit add wraps 0xFFF to 0x000
                     r_mem_memreq <= 1'b1;
                     r_mem_addr   <= r_mem_addr + 12'd1;
                  end
                  r_state <= S_ACC1;
               end
            end
            S_ACC1: begin
               r_mem_memreq <= 1'b0;
               r_mem_we     <= 1'b0;
               if (r_op == OP_READ16) begin
                  r_hi    <= io_bus.mem_rdata;
                  r_state <= S_CAP1;
               end else begin
                  r_rd_data <= {8'h00, io_bus.mem_rdata};
                  r_done    <= 1'b1;
                  r_err     <= r_err_pend;
                  r_state   <= S_DONE;
               end
            end
            S_CAP1: begin
               r_rd_data <= {r_hi, io_bus.mem_rdata};
               r_done    <= 1'b1;
               r_err     <= r_err_pend;
               r_state   <= S_DONE;
            end
            S_DONE: begin
               r_op_ready <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: begin
               r_op_ready   <= 1'b1;
               r_mem_memreq <= 1'b0;
               r_mem_we     <= 1'b0;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign io_bus.op_ready   = r_op_ready;
   assign io_bus.done       = r_done;
   assign io_bus.err        = r_err;
   assign io_bus.rd_data    = r_rd_data;
   assign io_bus.sp         = r_sp;
   assign io_bus.mem_memreq = r_mem_memreq;
   assign io_bus.mem_we     = r_mem_we;
   assign io_bus.mem_addr   = r_mem_addr;
   assign io_bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: a behavioural 4 KB responder with one-cycle registered
// read, a driver that pushes the expected result of each operation into a
// scoreboard queue, and a monitor that pops and checks on every done pulse.
module tb_mem_master;
   logic clk;
   logic reset;
   int   cyc;
   int   total;
   int   bad;

   mem_master_if bus ();

   mem_master dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [15:0] rd;
      logic        err;
      int          lat;
      int          nreq;
      logic [7:0]  sp;
      int          drv_cyc;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  ram [0:4095];
   logic [11:0] rd_addr_last;
   logic [11:0] rd_addr_prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // cycle counter
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // responder model: write at the request edge, read data registered
   initial begin
      bus.mem_rdata = 8'h00;
      rd_addr_last  = 12'h000;
      rd_addr_prev  = 12'h000;
      forever begin
         @(posedge clk);
         if (bus.mem_memreq) begin
            if (bus.mem_we) begin
               ram[bus.mem_addr] = bus.mem_wdata;
            end else begin
               bus.mem_rdata <= ram[bus.mem_addr];
               rd_addr_prev  = rd_addr_last;
               rd_addr_last  = bus.mem_addr;
            end
         end
      end
   end

   // monitor / scoreboard
   initial begin
      int   nreq;
      exp_t x;
      nreq = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            nreq = 0;
         end else begin
            if (bus.mem_memreq) nreq++;
            if (bus.err && !bus.done) chk("err_without_done", 32'(bus.err), 32'd0);
            if (bus.done) begin
               if (sb.size() == 0) begin
                  chk("unexpected_done", 32'(bus.done), 32'd0);
               end else begin
                  x = sb.pop_front();
                  chk($sformatf("op%0d_rd_data", x.id), 32'(bus.rd_data), 32'(x.rd));
                  chk($sformatf("op%0d_err", x.id), 32'(bus.err), 32'(x.err));
                  chk($sformatf("op%0d_latency", x.id), 32'(cyc - x.drv_cyc), 32'(x.lat));
                  chk($sformatf("op%0d_memreq_cycles", x.id), 32'(nreq), 32'(x.nreq));
                  chk($sformatf("op%0d_sp", x.id), 32'(bus.sp), 32'(x.sp));
               end
               nreq = 0;
            end
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.op_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.op_ready) chk("op_ready_timeout", 32'(bus.op_ready), 32'd1);
   endtask

   int op_id = 0;

   // called at a negedge; returns at a negedge with the DUT idle again
   task automatic issue(input logic [2:0] o, input logic [11:0] a, input logic [7:0] w,
                        input logic [15:0] rd, input logic e, input int lat,
                        input int nreq, input logic [7:0] s);
      exp_t x;
      wait_ready();
      bus.op_valid = 1'b1;
      bus.op       = o;
      bus.op_addr  = a;
      bus.op_wdata = w;
      op_id++;
      x.id      = op_id;
      x.rd      = rd;
      x.err     = e;
      x.lat     = lat;
      x.nreq    = nreq;
      x.sp      = s;
      x.drv_cyc = cyc;
      sb.push_back(x);
      @(posedge clk);
      @(negedge clk);
      // inputs are don't-care once accepted; scramble them
      bus.op_valid = 1'b0;
      bus.op       = 3'($urandom_range(0, 7));
      bus.op_addr  = 12'($urandom);
      bus.op_wdata = 8'($urandom);
      wait_ready();
   endtask

   initial begin
      int n;
      total = 0;
      bad   = 0;
      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      reset        = 1'b1;
      bus.op_valid = 1'b1;      // must be ignored while reset is high
      bus.op       = 3'd1;
      bus.op_addr  = 12'h321;
      bus.op_wdata = 8'hEE;
      repeat (3) @(negedge clk);
      bus.op_valid = 1'b0;
      reset        = 1'b0;

      // idle after reset
      for (int i = 0; i < 5; i++) begin
         chk("idle_op_ready", 32'(bus.op_ready), 32'd1);
         chk("idle_sp", 32'(bus.sp), 32'hFF);
         chk("idle_memreq", 32'(bus.mem_memreq), 32'd0);
         chk("idle_rd_data", 32'(bus.rd_data), 32'h0000);
         @(negedge clk);
      end
      chk("reset_ignored_write", 32'(ram[12'h321]), 32'h00);

      //    op     addr     wdata  rd        err   lat nreq sp
      issue(3'd1, 12'h123, 8'h5A, 16'h0000, 1'b0, 2, 1, 8'hFF);  // WRITE
      issue(3'd0, 12'h123, 8'h00, 16'h005A, 1'b0, 3, 1, 8'hFF);  // READ
      issue(3'd2, 12'h000, 8'h11, 16'h005A, 1'b0, 2, 1, 8'hFE);  // PUSH
      issue(3'd2, 12'h000, 8'h22, 16'h005A, 1'b0, 2, 1, 8'hFD);  // PUSH
      chk("push1_landed_fff", 32'(ram[12'hFFF]), 32'h11);
      chk("push2_landed_ffe", 32'(ram[12'hFFE]), 32'h22);
      issue(3'd3, 12'h000, 8'h00, 16'h0022, 1'b0, 3, 1, 8'hFE);  // POP
      issue(3'd3, 12'h000, 8'h00, 16'h0011, 1'b0, 3, 1, 8'hFF);  // POP

      ram[12'hFFF] = 8'hAB;
      ram[12'h000] = 8'hCD;
      issue(3'd4, 12'hFFF, 8'h00, 16'hABCD, 1'b0, 4, 2, 8'hFF);  // READ16 wraps
      chk("read16_first_addr", 32'(rd_addr_prev), 32'hFFF);
      chk("read16_second_addr", 32'(rd_addr_last), 32'h000);

      ram[12'hF00] = 8'h77;
      issue(3'd3, 12'h555, 8'h00, 16'h0077, 1'b1, 3, 1, 8'h00);  // POP wrap
      chk("pop_wrap_addr", 32'(rd_addr_last), 32'hF00);
      issue(3'd2, 12'h555, 8'h99, 16'h0077, 1'b1, 2, 1, 8'hFF);  // PUSH wrap
      chk("push_wrap_landed_f00", 32'(ram[12'hF00]), 32'h99);
      issue(3'd6, 12'h123, 8'h42, 16'h0077, 1'b1, 1, 0, 8'hFF);  // illegal
      chk("illegal_no_write", 32'(ram[12'h123]), 32'h5A);
      issue(3'd2, 12'h000, 8'h33, 16'h0077, 1'b0, 2, 1, 8'hFE);  // PUSH before abort

      // READ16 aborted by reset in its CAP1 cycle (no scoreboard entry)
      wait_ready();
      bus.op_valid = 1'b1;
      bus.op       = 3'd4;
      bus.op_addr  = 12'h123;
      @(posedge clk);
      @(negedge clk);            // ACC0
      bus.op_valid = 1'b0;
      @(negedge clk);            // ACC1
      @(negedge clk);            // CAP1
      chk("abort_in_cap1_no_done", 32'(bus.done), 32'd0);
      chk("abort_in_cap1_not_ready", 32'(bus.op_ready), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_op_ready", 32'(bus.op_ready), 32'd1);
      chk("abort_rd_data", 32'(bus.rd_data), 32'h0000);
      chk("abort_sp", 32'(bus.sp), 32'hFF);
      chk("abort_memreq", 32'(bus.mem_memreq), 32'd0);
      chk("abort_we", 32'(bus.mem_we), 32'd0);
      repeat (6) @(negedge clk);  // monitor flags any stray done
      chk("abort_rd_data_later", 32'(bus.rd_data), 32'h0000);

      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got cycle %0d expected end", cyc);
      $fatal(1);
   end
endmodule

// File: doc/mem_master.md
# mem_master

Memory-bus initiator that sits between the CPU sequencer and the 4 KB byte-wide `ram_memory` responder. It accepts one byte or word operation at a time from the CPU and drives the responder's `memreq`/`we`/`addr`/`data_in` lines. It captures read data returned with the responder's one-cycle registered read latency. It also owns the hardware stack pointer and generates stack addresses in page 0xF.

## Interface
- `STACK_PAGE`, 4'hF: upper address nibble for all stack accesses.
- `SP_RESET`, 8'hFF: stack pointer value after reset.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  CPU presents an operation.
- `op`  in  3  0 READ, 1 WRITE, 2 PUSH, 3 POP, 4 READ16; 5–7 illegal.
- `op_addr`  in  12  byte address for READ, WRITE and READ16; ignored for stack operations.
- `op_wdata`  in  8  write data for WRITE and PUSH.
- `op_ready`  out  1  high only in IDLE; an operation is accepted on an edge where `op_valid & op_ready`.
- `done`  out  1  one-cycle completion pulse.
- `rd_data`  out  16  read result; held until the next `done`.
- `err`  out  1  one-cycle pulse, concurrent with `done`, for stack wrap or illegal op.
- `sp`  out  8  current stack pointer.
- `mem_memreq`, `mem_we`  out  1 each  registered request and write-enable to the responder.
- `mem_addr`  out  12  registered address to the responder.
- `mem_wdata`  out  8  registered data to the responder's `data_in`.
- `mem_rdata`  in  8  responder's `data_out`.

## Operation
- States: IDLE, ACC0, ACC1, CAP1, DONE.
- IDLE → ACC0 on accept, for every legal op. Illegal ops go IDLE → DONE with `err`; they make no memory access and leave `sp` unchanged.
- ACC0: `mem_memreq=1`.
  - WRITE/PUSH: `mem_we=1`. Next state is DONE.
  - READ/POP: `mem_we=0`. Next state is ACC1.
  - READ16: `mem_we=0`. Next state is ACC1.
- ACC1: `mem_memreq=0`. `mem_rdata` now holds the byte requested in ACC0; it is captured at the end of this cycle.
  - READ/POP: result is `{8'h00, byte}`. Next state is DONE.
  - READ16: the captured byte becomes the high byte. ACC1 also issues a second request with `mem_memreq=1` and `mem_addr=(op_addr+1) mod 4096`, so 0xFFF wraps to 0x000. Next state is CAP1.
- CAP1: captures the low byte. Next state is DONE.
- DONE: `done=1` for one cycle. `rd_data` updates at entry to DONE for reads, and is unchanged for writes and illegal ops. Next state is IDLE.
- Byte order for READ16 is big-endian: the byte at `op_addr` is `rd_data[15:8]`.
- Stack operations (descending stack, `sp` points at the next free slot):
  - PUSH writes `op_wdata` to `{STACK_PAGE, sp}`, then `sp ← sp−1`.
  - POP reads `{STACK_PAGE, sp+1}` and sets `sp ← sp+1`.
  - Arithmetic is mod 256. `sp` updates on the accept edge.
  - A PUSH with `sp==8'h00` still writes 0xF00 and wraps `sp` to 0xFF.
  - A POP with `sp==8'hFF` reads 0xF00 and wraps `sp` to 0x00.
  - Both wrap cases raise `err` together with `done`.
- All `mem_*` outputs are flops. When `mem_memreq=0`, `mem_we` is 0. `mem_addr` and `mem_wdata` hold their last values.
- While `op_ready=0`, `op_*` inputs are ignored. The CPU does not need to hold them stable after acceptance, because they are latched on accept.

## Timing
- Edge E0 = accept edge.
- WRITE/PUSH: request in the cycle after E0. The responder writes at E1. `done` is high in the cycle after E1. Accept-to-`done` = 2 cycles. IDLE again 3 cycles after E0.
- READ/POP: request after E0, capture at E2, `done` after E2. Accept-to-`done` = 3 cycles.
- READ16: `done` 4 cycles after E0.
- Minimum spacing between accepts: 3 cycles (writes), 4 (READ/POP), 5 (READ16).
- Reset values: state IDLE, `op_ready=1`, `done=0`, `err=0`, `rd_data=16'h0000`, `sp=SP_RESET`, and all `mem_*` = 0.
- Reset asserted mid-operation:
  - The next cycle is IDLE with `mem_memreq=0`.
  - No `done` is produced.
  - Captured bytes are discarded.
  - `sp` returns to `SP_RESET`, even if a PUSH/POP had already adjusted it.
  - A write whose request cycle coincides with the reset edge has already been committed by the responder. That write is not rolled back.
- `op_valid` with reset high is ignored.

## Test plan
- Reset, then idle 5 cycles → `op_ready=1`, `sp=8'hFF`, `mem_memreq=0` throughout, `rd_data=16'h0000`.
- WRITE 0x5A to 0x123, then READ 0x123 → WRITE `done` 2 cycles after accept; READ `done` 3 cycles after accept with `rd_data=16'h005A`; exactly one `mem_memreq` cycle for each op.
- PUSH 0x11, PUSH 0x22, POP, POP → writes land at 0xFFF then 0xFFE; `sp` goes FF→FE→FD→FE→FF; POP results are 0x0022 then 0x0011; `err` stays 0.
- Preload 0xFFF=0xAB and 0x000=0xCD, then READ16 at 0xFFF → second request address is 0x000; `rd_data=16'hABCD` 4 cycles after accept.
- POP at `sp=8'hFF` → reads 0xF00, `sp=8'h00`, and `err` and `done` coincide. `op=3'd6` → `done` and `err` 1 cycle after accept, no `mem_memreq`.
- Reset asserted in the CAP1 cycle of a READ16 → no `done`, IDLE next cycle, `rd_data=16'h0000`, `sp=8'hFF`.
